if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset (bits [1:0] are ignored).
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port mem_req, output, 1 bit: instruction-memory fetch request.
REQ-005 The block SHALL have port mem_addr, output, 32 bits: fetch byte address, word-aligned.
REQ-006 The block SHALL have port mem_ack, input, 1 bit: memory accepts the request this cycle.
REQ-007 The block SHALL have port mem_rvalid, input, 1 bit: read data valid for the outstanding request.
REQ-008 The block SHALL have port mem_rdata, input, 32 bits: instruction word returned by memory.
REQ-009 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect from execute.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-011 The block SHALL have port inst_valid, output, 1 bit: the fetch queue head is valid.
REQ-012 The block SHALL have port inst, output, 32 bits: head instruction word, 0 when inst_valid=0.
REQ-013 The block SHALL have port inst_pc, output, 32 bits: head instruction address, 0 when inst_valid=0.
REQ-014 The block SHALL have port inst_ready, input, 1 bit: decode accepts the head; low means stall.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, FETCH, WAIT and DROP, plus a 2-entry FIFO of {pc, inst} and a 32-bit pc register.
REQ-016 In IDLE, the block SHALL go to FETCH on the next cycle; mem_req SHALL be 0 in IDLE.
REQ-017 mem_req SHALL be 1 when state=FETCH, fifo count<2 and redirect_valid=0; mem_addr SHALL always equal pc.
REQ-018 While mem_req=1 and mem_ack=0, mem_req and mem_addr SHALL hold stable.
REQ-019 When mem_req=1 and mem_ack=1, the block SHALL go FETCH->WAIT and set pc <= pc+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 At most one request SHALL be outstanding; mem_rvalid is legal no earlier than the cycle after ack.
REQ-021 In WAIT, when mem_rvalid=1 and redirect_valid=0, the block SHALL push {pc-4, mem_rdata} into the FIFO and go to FETCH.
REQ-022 A pop SHALL occur when inst_valid=1 and inst_ready=1; push and pop in the same cycle SHALL leave the count unchanged.
REQ-023 A request SHALL only be issued when count<2, so a push never overflows the FIFO; the FIFO order SHALL be strictly first-in, first-out.
REQ-024 When redirect_valid=1 in any non-IDLE state, the block SHALL:
  - set pc <= {redirect_pc[31:2], 2'b00};
  - flush the FIFO, so inst_valid=0 next cycle;
  - give redirect priority over any same-cycle pop or push.
REQ-025 Redirect in FETCH: the block SHALL stay in FETCH; mem_req is 0 that cycle and the first request to the new pc comes next cycle.
REQ-026 Redirect in WAIT with mem_rvalid=0: the block SHALL go to DROP.
REQ-027 Redirect in WAIT with mem_rvalid=1: the block SHALL discard the data and go to FETCH.
REQ-028 In DROP, mem_req SHALL be 0; on mem_rvalid=1 the block SHALL discard the data and go to FETCH.
REQ-029 Redirect in DROP SHALL update pc and leave the state in DROP, unless mem_rvalid=1 in the same cycle, in which case the state SHALL go to FETCH.
REQ-030 mem_rvalid in IDLE or FETCH SHALL be ignored and SHALL NOT alter state or the FIFO.
REQ-031 With mem_ack tied to 1 and rvalid one cycle after ack, steady-state throughput SHALL be one instruction per 2 cycles.

Reset
REQ-032 On a clk edge with reset=1, the block SHALL set:
  - state=IDLE, pc=RESET_PC with bits [1:0] cleared, FIFO count=0;
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
REQ-033 Reset asserted mid-request SHALL abandon the outstanding request; any later stray mem_rvalid in IDLE/FETCH is ignored per REQ-030.
REQ-034 The first mem_req SHALL assert on the second cycle after reset deasserts.

Verification
REQ-035 Scenario, basic fetch: reset, ack=1, rvalid one cycle after ack, inst_ready=1 -> mem_addr sequence 0,4,8; inst_pc sequence 0,4,8 with matching rdata.
REQ-036 Scenario, backpressure: inst_ready=0 -> exactly 2 requests issued, then mem_req stays 0; raising inst_ready resumes fetch at addr 8.
REQ-037 Scenario, redirect in WAIT: redirect_pc=32'h0000_0016 while waiting -> state DROP; the late rdata is discarded; the next mem_addr is 32'h0000_0014 and inst_valid=0 until its data returns.
REQ-038 Scenario, redirect and rvalid in the same cycle: the data is not pushed; the next request goes to the redirect target.
REQ-039 Scenario, wrap-around: redirect to 32'hFFFF_FFFC -> the following fetch address is 32'h0000_0000.
REQ-040 Scenario, mem_ack stall: ack held low for 3 cycles -> mem_req and mem_addr stable throughout; pc advances only on ack.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: single outstanding memory request, 2-entry {pc, inst}
// queue toward decode, and redirect handling that flushes the queue and squashes late data.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    // state | meaning
    // IDLE  | one cycle after reset, no request
    // FETCH | issue a request to pc when the queue has room
    // WAIT  | request accepted, waiting for its read data
    // DROP  | request squashed by a redirect, discard its read data
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_pc_aligned;

    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_inst [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic        flush;

    logic        unused_redirect_bits;

    assign redirect_pc_aligned  = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign mem_req    = (state == FETCH) && (count < 2'd2) && !redirect_valid;
    assign mem_addr   = pc;
    assign inst_valid = (count != 2'd0);
    assign inst       = inst_valid ? fifo_inst[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign pop        = inst_valid && inst_ready;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc_aligned;
                end else if (mem_req && mem_ack) begin
                    pc_next    = pc + 32'd4;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    pc_next    = redirect_pc_aligned;
                    state_next = mem_rvalid ? FETCH : DROP;
                end else if (mem_rvalid) begin
                    push       = 1'b1;
                    state_next = FETCH;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc_aligned;
                end
                if (mem_rvalid) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC_ALIGNED;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            // Redirect wins over any same-cycle push or pop.
            if (flush) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // The fetched word belongs to the address before the already-incremented pc.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_pc[wr_ptr]   <= pc - 32'd4;
            fifo_inst[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: linear stimulus, hand-computed expectations.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks = 0;
    int errors = 0;

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc_e,
                            input logic [31:0] inst_e);
        chk({tag, "_valid"}, {31'h0, inst_valid}, {31'h0, v});
        chk({tag, "_pc"}, inst_pc, pc_e);
        chk({tag, "_inst"}, inst, inst_e);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        mem_ack        = 1'b1;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        #1;
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk_head("rst_head", 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_idle_req", {31'h0, mem_req}, 32'h0);
        tick();
        #1;
        chk("rst_first_req", {31'h0, mem_req}, 32'h1);
    endtask

    // Starts in FETCH with ack=1; returns one cycle after the data is pushed.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        #1;
        chk("fo_req", {31'h0, mem_req}, 32'h1);
        chk("fo_addr", mem_addr, addr);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        #1;
        chk("fo_wait_req", {31'h0, mem_req}, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #1;
    endtask

    initial begin
        inst_ready = 1'b1;

        // Basic fetch: 0, 4, 8 with one instruction per two cycles.
        do_reset();
        fetch_one(32'h0, 32'hA000_0000);
        chk_head("basic0", 1'b1, 32'h0, 32'hA000_0000);
        fetch_one(32'h4, 32'hA000_0004);
        chk_head("basic4", 1'b1, 32'h4, 32'hA000_0004);
        fetch_one(32'h8, 32'hA000_0008);
        chk_head("basic8", 1'b1, 32'h8, 32'hA000_0008);

        // Backpressure: two requests fill the queue, then no more.
        inst_ready = 1'b0;
        do_reset();
        fetch_one(32'h0, 32'hB000_0000);
        fetch_one(32'h4, 32'hB000_0004);
        for (int i = 0; i < 3; i++) begin
            chk("bp_full_req", {31'h0, mem_req}, 32'h0);
            chk("bp_full_addr", mem_addr, 32'h8);
            chk_head("bp_hold", 1'b1, 32'h0, 32'hB000_0000);
            tick();
            #1;
        end
        inst_ready = 1'b1;
        #1;
        chk("bp_release_req", {31'h0, mem_req}, 32'h0);
        tick();
        chk_head("bp_second", 1'b1, 32'h4, 32'hB000_0004);
        fetch_one(32'h8, 32'hB000_0008);
        chk_head("bp_resume", 1'b1, 32'h8, 32'hB000_0008);

        // Redirect while waiting: squash late data, refetch from 0x14.
        #1;
        chk("rw_addr", mem_addr, 32'hC);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0016;
        #1;
        chk("rw_wait_req", {31'h0, mem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rw_drop_req", {31'h0, mem_req}, 32'h0);
        chk("rw_drop_addr", mem_addr, 32'h14);
        chk("rw_flushed", {31'h0, inst_valid}, 32'h0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("rw_drop2_req", {31'h0, mem_req}, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("rw_discarded", {31'h0, inst_valid}, 32'h0);
        fetch_one(32'h14, 32'hC000_0014);
        chk_head("rw_target", 1'b1, 32'h14, 32'hC000_0014);

        // Redirect and rvalid together: data dropped, next request to target.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        mem_rvalid     = 1'b1;
        mem_rdata      = 32'hBAD0_0018;
        #1;
        tick();
        redirect_valid = 1'b0;
        mem_rvalid     = 1'b0;
        #1;
        chk("rr_no_push", {31'h0, inst_valid}, 32'h0);
        chk("rr_req", {31'h0, mem_req}, 32'h1);
        chk("rr_addr", mem_addr, 32'h100);

        // Redirect in FETCH to the top word, then wrap to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        chk("wr_redir_req", {31'h0, mem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'hE000_FFFC);
        chk_head("wr_top", 1'b1, 32'hFFFF_FFFC, 32'hE000_FFFC);
        chk("wr_wrap_addr", mem_addr, 32'h0);

        // Ack stall: request and address hold; a stray rvalid in FETCH is ignored.
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = (i == 1);
            mem_rdata  = 32'h5A5A_5A5A;
            #1;
            chk("st_req", {31'h0, mem_req}, 32'h1);
            chk("st_addr", mem_addr, 32'h0);
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("st_stray_ignored", {31'h0, inst_valid}, 32'h0);
        mem_ack = 1'b1;
        #1;
        chk("st_ack_addr", mem_addr, 32'h0);
        tick();
        #1;
        chk("st_pc_adv", mem_addr, 32'h4);
        chk("st_wait_req", {31'h0, mem_req}, 32'h0);

        // Reset while waiting abandons the request; stray rvalid afterwards ignored.
        do_reset();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        mem_ack    = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("rst_stray_ignored", {31'h0, inst_valid}, 32'h0);
        chk("rst_stray_addr", mem_addr, 32'h0);
        chk("rst_stray_req", {31'h0, mem_req}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
